alu_issue_stage: RTL
====================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk_i input 1 (all state updates on rising edge); rst_i input 1 (active-low, synchronous).
REQ-002 valid_i  input  1  upstream operation valid.
REQ-003 ready_o  output 1  block can accept an operation this cycle.
REQ-004 aluop_i  input  3  main-decoder ALU operation class.
REQ-005 funct_i  input  6  R-type function field.
REQ-006 rs_data_i  input  32  register operand A.
REQ-007 rt_data_i  input  32  register operand B.
REQ-008 imm_i  input  16  instruction immediate.
REQ-009 alusrc_i  input  1  1 = operand B is the extended immediate.
REQ-010 flush_i  input  1  discard all buffered operations.
REQ-011 src1_o  output 32  ALU operand 1.
REQ-012 src2_o  output 32  ALU operand 2.
REQ-013 ctrl_o  output 4  ALU control code.
REQ-014 valid_o  output 1  src1_o, src2_o and ctrl_o hold a valid operation.
REQ-015 ready_i  input  1  downstream consumes the head operation.
REQ-016 illegal_o  output 1  head operation had an undefined aluop/funct combination.
REQ-017 issue_cnt_o  output 16  count of completed output handshakes.

Function
REQ-018 ALU codes SHALL be: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
REQ-019 Decode SHALL map aluop 000 to ADD, 001 to SUB, 011 to SLT, 100 to OR, and 101 to AND.
REQ-020 When aluop is 010, decode SHALL use funct: 100000 to ADD, 100010 to SUB, 100100 to AND, 100101 to OR, 101010 to SLT.
REQ-021 Any other aluop/funct combination SHALL decode to ADD (0010) with the stored illegal flag set.
REQ-022 The immediate SHALL be sign-extended for aluop 000/001/011 and zero-extended for aluop 100/101; for any other aluop it SHALL be sign-extended.
REQ-023 Operand B SHALL be the extended immediate when alusrc_i=1, else rt_data_i; operand A SHALL always be rs_data_i.
REQ-024 Decode and operand selection SHALL occur at acceptance; each buffer entry SHALL store {src1, src2, ctrl, illegal}.
REQ-025 The buffer SHALL be a 2-entry FIFO with read and write pointers that wrap modulo 2 and a 0..2 occupancy count.
REQ-026 Accept occurs when valid_i & ready_o; ready_o SHALL equal (count<2) & ~flush_i.
REQ-027 Pop occurs when valid_o & ready_i; valid_o SHALL equal (count!=0).
REQ-028 src1_o, src2_o, ctrl_o and illegal_o SHALL show the head entry while valid_o=1 and SHALL be 0 when valid_o=0.
REQ-029 Latency SHALL be one cycle: an operation accepted at edge N into an empty buffer appears on the outputs after edge N with valid_o=1.
REQ-030 Accept and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-031 When the buffer is full, ready_o SHALL be 0 and valid_i SHALL be ignored; a pop in that cycle makes ready_o=1 on the next cycle.
REQ-032 While valid_o=1 and ready_i=0, all outputs SHALL hold stable.
REQ-033 flush_i=1 at an edge SHALL set count=0 and both pointers to 0, and SHALL neither accept nor pop that cycle.
REQ-034 issue_cnt_o SHALL increment by 1 on each pop, wrapping from 16'hFFFF to 0, and SHALL not change on flush.

Reset
REQ-035 With rst_i=0 at a rising edge, count, pointers and issue_cnt_o SHALL clear to 0, and reset SHALL take priority over flush, accept and pop.
REQ-036 Outputs SHALL read ready_o=1, valid_o=0, src1_o=src2_o=0, ctrl_o=0000, illegal_o=0 while rst_i=0 and after release until the first accept.
REQ-037 Reset asserted mid-operation SHALL drop all buffered entries; entry contents need not be cleared.

Verification
REQ-038 aluop=010, funct=100010, rs=5, rt=3, alusrc=0, ready_i=1 -> next cycle valid_o=1, src1=5, src2=3, ctrl=0110, illegal=0, issue_cnt=1 after pop.
REQ-039 aluop=011, imm=16'hFFFF, alusrc=1, then aluop=100, imm=16'hFFFF, alusrc=1 -> src2=32'hFFFFFFFF with ctrl=0111, then src2=32'h0000FFFF with ctrl=0001.
REQ-040 ready_i=0, three back-to-back valid_i -> ready_o=0 after two accepts, third held; outputs stable; ready_i=1 then drains in order.
REQ-041 aluop=010, funct=000000 -> ctrl_o=0010, illegal_o=1.
REQ-042 Buffer full, flush_i=1 with valid_i=1 -> next cycle valid_o=0, count 0, nothing accepted; issue_cnt unchanged.
REQ-043 rst_i=0 with 2 entries buffered -> valid_o=0, ready_o=1, issue_cnt_o=0 after the edge; also issue_cnt at FFFF plus one pop -> 0000.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes aluop/funct, selects operands, and buffers {src1, src2, ctrl, illegal} in a 2-entry FIFO.
// One-cycle latency from accept to output; ready_o drops when full or flushing, and outputs hold while ready_i is low.
module alu_issue_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [2:0]  aluop_i,
    input  logic [5:0]  funct_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic [15:0] imm_i,
    input  logic        alusrc_i,
    input  logic        flush_i,
    output logic [31:0] src1_o,
    output logic [31:0] src2_o,
    output logic [3:0]  ctrl_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        illegal_o,
    output logic [15:0] issue_cnt_o
);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;

    typedef struct packed {
        logic [31:0] src1;
        logic [31:0] src2;
        logic [3:0]  ctrl;
        logic        illegal;
    } entry_t;

    entry_t      mem_q [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [15:0] issue_cnt_q, issue_cnt_d;

    logic [3:0]  dec_ctrl;
    logic        dec_illegal;
    logic [31:0] imm_ext;
    entry_t      new_entry;
    entry_t      head;
    logic        accept;
    logic        pop;
    logic        can_accept;
    logic        has_data;

    always_comb begin
        dec_ctrl    = CTRL_ADD;
        dec_illegal = 1'b0;
        case (aluop_i)
            3'b000: dec_ctrl = CTRL_ADD;
            3'b001: dec_ctrl = CTRL_SUB;
            3'b011: dec_ctrl = CTRL_SLT;
            3'b100: dec_ctrl = CTRL_OR;
            3'b101: dec_ctrl = CTRL_AND;
            3'b010: begin
                case (funct_i)
                    6'b100000: dec_ctrl = CTRL_ADD;
                    6'b100010: dec_ctrl = CTRL_SUB;
                    6'b100100: dec_ctrl = CTRL_AND;
                    6'b100101: dec_ctrl = CTRL_OR;
                    6'b101010: dec_ctrl = CTRL_SLT;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Logical ops (OR/AND) take a zero-extended immediate; everything else sign-extends.
    always_comb begin
        if (aluop_i == 3'b100 || aluop_i == 3'b101) begin
            imm_ext = {16'h0000, imm_i};
        end else begin
            imm_ext = {{16{imm_i[15]}}, imm_i};
        end
        new_entry.src1    = rs_data_i;
        new_entry.src2    = alusrc_i ? imm_ext : rt_data_i;
        new_entry.ctrl    = dec_ctrl;
        new_entry.illegal = dec_illegal;
    end

    assign has_data   = (count_q != 2'd0);
    assign can_accept = (count_q != 2'd2) && !flush_i;

    // Handshake outputs read idle while reset is held, even before the first reset edge.
    assign ready_o = !rst_i || can_accept;
    assign valid_o = rst_i && has_data;

    assign accept = rst_i && valid_i && can_accept;
    assign pop    = rst_i && has_data && ready_i && !flush_i;

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        src1_o    = 32'h0;
        src2_o    = 32'h0;
        ctrl_o    = 4'h0;
        illegal_o = 1'b0;
        if (valid_o) begin
            src1_o    = head.src1;
            src2_o    = head.src2;
            ctrl_o    = head.ctrl;
            illegal_o = head.illegal;
        end
    end

    assign issue_cnt_o = issue_cnt_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        issue_cnt_d = issue_cnt_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (accept) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d    = ~rd_ptr_q;
                issue_cnt_d = issue_cnt_q + 16'd1;
            end
            case ({accept, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            issue_cnt_q <= 16'h0000;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    // Storage is never reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

endmodule
